// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between the core datapath and a single memory port.
//   Latches one request, drives one (or, with splitting, two) memory beats with lane-aligned
//   store data and byte enables, and returns a one-cycle response carrying the sign- or
//   zero-extended load data (zero for stores and rejected accesses).
//
// Build option: MEM_ACCESS_UNIT_SPLIT_EN
//   undefined : any access with (addr mod NB) not a multiple of its size is rejected (rsp_err).
//   defined   : misaligned accesses are served; one crossing a beat boundary takes two beats.
//
// Ports
//   clk, rst            clock (rising edge); asynchronous active-low reset
//   req_valid/req_ready request handshake; req_we, req_funct3, req_addr, req_wdata qualify it
//   rsp_valid           one-cycle response strobe with rsp_rdata and rsp_err
//   mem_read/mem_write  memory strobes, held with mem_address/mem_wdata/mem_byte_enable
//   mem_rdata/mem_resp  memory completion of the current beat
//   dbg_state           current FSM state (IDLE=0, BEAT0=1, BEAT1=2, RESP=3)
//
// Handshake: a request transfers on a rising edge where req_valid and req_ready are both 1.
// req_ready is 1 only in IDLE and never waits on req_valid; req_valid seen outside IDLE is
// ignored. rsp_valid has no back-pressure: it is high for exactly one cycle per request.

module mem_access_unit #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [2:0]          req_funct3,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [XLEN-1:0]     req_wdata,
   output logic                rsp_valid,
   output logic [XLEN-1:0]     rsp_rdata,
   output logic                rsp_err,
   output logic                mem_read,
   output logic                mem_write,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [XLEN-1:0]     mem_wdata,
   output logic [XLEN/8-1:0]   mem_byte_enable,
   input  logic [XLEN-1:0]     mem_rdata,
   input  logic                mem_resp,
   output logic [1:0]          dbg_state
);

   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);
   localparam logic [ADDR_W-1:0] NB_STEP = ADDR_W'(NB);

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

   state_t              st;
   logic                we_q;
   logic [1:0]          size_q;
   logic                uns_q;
   logic [OFF_W-1:0]    off_q;
   logic                split_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [XLEN-1:0]     wdata_hi_q;
   logic [NB-1:0]       be_hi_q;
   logic [XLEN-1:0]     rdata_lo_q;

   // Request decode
   logic [OFF_W-1:0]    off;
   logic [3:0]          nbytes;
   logic [4:0]          span;
   logic                too_big, uns_bad, misalign, split, illegal;
   logic [7:0]          byte_mask;
   logic [2*NB-1:0]     be_full;
   logic [2*XLEN-1:0]   wd_full;
   logic [ADDR_W-1:0]   beat_addr;

   always_comb begin
      off       = req_addr[OFF_W-1:0];
      nbytes    = 4'd1 << req_funct3[1:0];
      span      = 5'(off) + 5'(nbytes);
      too_big   = nbytes > 4'(NB);
      uns_bad   = req_funct3[2] && (req_we || nbytes == 4'(NB));
`ifdef MEM_ACCESS_UNIT_SPLIT_EN
      misalign  = 1'b0;
      split     = span > 5'(NB);
`else
      misalign  = (4'(off) & (nbytes - 4'd1)) != 4'd0;
      split     = 1'b0;
`endif
      illegal   = too_big || uns_bad || misalign;
      case (req_funct3[1:0])
         2'd0:    byte_mask = 8'h01;
         2'd1:    byte_mask = 8'h03;
         2'd2:    byte_mask = 8'h0F;
         default: byte_mask = 8'hFF;
      endcase
      // Double-width lane vectors: the low half feeds beat 0, the high half beat 1.
      be_full   = (2*NB)'(byte_mask) << off;
      wd_full   = {{XLEN{1'b0}}, req_wdata} << {off, 3'b000};
      beat_addr = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   end

   // Load extraction: beat 0 bytes sit below beat 1 bytes, then shift down by the offset.
   logic [2*XLEN-1:0]   ld_buf;
   logic [XLEN-1:0]     ld_low, mask, ld_val;
   logic [XLEN:0]       one_sh;
   logic [6:0]          nbits;
   logic                sgn;

   always_comb begin
      ld_buf = (st == BEAT1) ? {mem_rdata, rdata_lo_q} : {{XLEN{1'b0}}, mem_rdata};
      ld_low = XLEN'(ld_buf >> {off_q, 3'b000});
      nbits  = 7'd8 << size_q;
      // A full-width load shifts the one out of range, so the mask wraps to all ones.
      one_sh = {{XLEN{1'b0}}, 1'b1} << nbits;
      mask   = one_sh[XLEN-1:0] - {{(XLEN-1){1'b0}}, 1'b1};
      sgn    = |(ld_low & mask & ~(mask >> 1));
      ld_val = (!uns_q && sgn) ? ((ld_low & mask) | ~mask) : (ld_low & mask);
   end

   assign req_ready = rst && (st == IDLE);
   assign dbg_state = st;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st              <= IDLE;
         we_q            <= 1'b0;
         size_q          <= 2'd0;
         uns_q           <= 1'b0;
         off_q           <= '0;
         split_q         <= 1'b0;
         addr_q          <= '0;
         wdata_hi_q      <= '0;
         be_hi_q         <= '0;
         rdata_lo_q      <= '0;
         rsp_valid       <= 1'b0;
         rsp_rdata       <= '0;
         rsp_err         <= 1'b0;
         mem_read        <= 1'b0;
         mem_write       <= 1'b0;
         mem_address     <= '0;
         mem_wdata       <= '0;
         mem_byte_enable <= '0;
      end else begin
         case (st)
            IDLE: begin
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               rsp_rdata <= '0;
               if (req_valid) begin
                  we_q       <= req_we;
                  size_q     <= req_funct3[1:0];
                  uns_q      <= req_funct3[2];
                  off_q      <= off;
                  split_q    <= split;
                  addr_q     <= beat_addr;
                  wdata_hi_q <= wd_full[2*XLEN-1:XLEN];
                  be_hi_q    <= be_full[2*NB-1:NB];
                  if (illegal) begin
                     st        <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                  end else begin
                     st              <= BEAT0;
                     mem_read        <= !req_we;
                     mem_write       <= req_we;
                     mem_address     <= beat_addr;
                     mem_wdata       <= wd_full[XLEN-1:0];
                     mem_byte_enable <= be_full[NB-1:0];
                  end
               end
            end
            BEAT0, BEAT1: begin
               if (mem_resp) begin
                  if (st == BEAT0 && split_q) begin
                     st              <= BEAT1;
                     rdata_lo_q      <= mem_rdata;
                     mem_address     <= addr_q + NB_STEP;
                     mem_wdata       <= wdata_hi_q;
                     mem_byte_enable <= be_hi_q;
                  end else begin
                     st              <= RESP;
                     mem_read        <= 1'b0;
                     mem_write       <= 1'b0;
                     mem_address     <= '0;
                     mem_wdata       <= '0;
                     mem_byte_enable <= '0;
                     rsp_valid       <= 1'b1;
                     rsp_rdata       <= we_q ? '0 : ld_val;
                  end
               end
            end
            default: begin
               st        <= IDLE;
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               rsp_rdata <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench for mem_access_unit (XLEN=32 instance plus an XLEN=64
// instance for double-word accesses). Expectations follow the MEM_ACCESS_UNIT_SPLIT_EN setting.

module tb_mem_access_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        mem_read, mem_write;
   logic [31:0] mem_address, mem_wdata, mem_rdata;
   logic [3:0]  mem_byte_enable;
   logic        mem_resp;
   logic [1:0]  dbg_state;

   logic        w_req_valid, w_req_ready;
   logic [2:0]  w_req_funct3;
   logic [31:0] w_req_addr, w_mem_address;
   logic [63:0] w_req_wdata, w_rsp_rdata, w_mem_wdata, w_mem_rdata;
   logic        w_rsp_valid, w_rsp_err, w_mem_read, w_mem_write, w_mem_resp;
   logic [7:0]  w_mem_byte_enable;
   logic [1:0]  w_dbg_state;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   mem_access_unit #(.XLEN(32), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable), .mem_rdata(mem_rdata),
      .mem_resp(mem_resp), .dbg_state(dbg_state)
   );

   mem_access_unit #(.XLEN(64), .ADDR_W(32)) dut64 (
      .clk(clk), .rst(rst), .req_valid(w_req_valid), .req_ready(w_req_ready), .req_we(1'b0),
      .req_funct3(w_req_funct3), .req_addr(w_req_addr), .req_wdata(w_req_wdata),
      .rsp_valid(w_rsp_valid), .rsp_rdata(w_rsp_rdata), .rsp_err(w_rsp_err),
      .mem_read(w_mem_read), .mem_write(w_mem_write), .mem_address(w_mem_address),
      .mem_wdata(w_mem_wdata), .mem_byte_enable(w_mem_byte_enable), .mem_rdata(w_mem_rdata),
      .mem_resp(w_mem_resp), .dbg_state(w_dbg_state)
   );

   // Driver: present a request at the falling edge; it is accepted at the next rising edge.
   task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   // Driver: complete the current beat in this cycle.
   task automatic mem_beat(input logic [31:0] rdata);
      mem_resp = 1'b1; mem_rdata = rdata;
      @(posedge clk); #1;
      mem_resp = 1'b0; mem_rdata = '0;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({req_ready, rsp_valid, rsp_err, mem_read, mem_write, dbg_state} !== 7'b0 ||
          rsp_rdata !== 32'h0 || mem_address !== 32'h0 || mem_wdata !== 32'h0 ||
          mem_byte_enable !== 4'h0 || w_req_ready !== 1'b0 || w_mem_read !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs: ready=%b rsp_valid=%b read=%b write=%b addr=%h want all zero",
                  req_ready, rsp_valid, mem_read, mem_write, mem_address);
      end
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      total++;
      if (req_ready !== 1'b1) begin
         bad++; $display("FAIL reset_release_ready: got %b want 1", req_ready);
      end
   endtask

   task automatic test_lb_wait;
      int s;
      drive_req(1'b0, 3'b000, 32'h103, 32'h0);
      s = cyc;
      total++;
      if ({mem_read, mem_write} !== 2'b10 || mem_address !== 32'h100 || mem_byte_enable !== 4'b1000
          || req_ready !== 1'b0) begin
         bad++;
         $display("FAIL lb_beat: rd=%b wr=%b addr=%h be=%b ready=%b want 1 0 00000100 1000 0",
                  mem_read, mem_write, mem_address, mem_byte_enable, req_ready);
      end
      repeat (3) begin
         @(posedge clk); #1;
         total++;
         if (rsp_valid !== 1'b0 || mem_read !== 1'b1 || mem_address !== 32'h100) begin
            bad++;
            $display("FAIL lb_hold: rsp_valid=%b rd=%b addr=%h want 0 1 00000100",
                     rsp_valid, mem_read, mem_address);
         end
      end
      mem_beat(32'h80AA_BBCC);
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hFFFF_FF80 || rsp_err !== 1'b0 || cyc - s != 4
          || mem_read !== 1'b0) begin
         bad++;
         $display("FAIL lb_rsp: valid=%b data=%h err=%b lat=%0d rd=%b want 1 ffffff80 0 4 0",
                  rsp_valid, rsp_rdata, rsp_err, cyc - s, mem_read);
      end
      @(posedge clk); #1;
      total++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         bad++; $display("FAIL lb_one_shot: valid=%b ready=%b want 0 1", rsp_valid, req_ready);
      end
   endtask

   task automatic test_store_sh;
      drive_req(1'b1, 3'b001, 32'h202, 32'h0000_1234);
      total++;
      if ({mem_read, mem_write} !== 2'b01 || mem_address !== 32'h200 ||
          mem_byte_enable !== 4'b1100 || mem_wdata !== 32'h1234_0000) begin
         bad++;
         $display("FAIL sh_beat: rd=%b wr=%b addr=%h be=%b wdata=%h want 0 1 00000200 1100 12340000",
                  mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata);
      end
      mem_beat(32'hDEAD_BEEF);
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
         bad++;
         $display("FAIL sh_rsp: valid=%b data=%h err=%b want 1 00000000 0",
                  rsp_valid, rsp_rdata, rsp_err);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_load_ext;
      logic [2:0]  f3   [3] = '{3'b001, 3'b100, 3'b010};
      logic [31:0] addr [3] = '{32'h206, 32'h101, 32'h040};
      logic [31:0] rd   [3] = '{32'h8001_5555, 32'h0000_F100, 32'h1234_5678};
      logic [31:0] exp  [3] = '{32'hFFFF_8001, 32'h0000_00F1, 32'h1234_5678};
      logic [3:0]  be   [3] = '{4'b1100, 4'b0010, 4'b1111};
      for (int i = 0; i < 3; i++) begin
         drive_req(1'b0, f3[i], addr[i], 32'h0);
         total++;
         if (mem_read !== 1'b1 || mem_byte_enable !== be[i] || mem_address !== {addr[i][31:2], 2'b00}) begin
            bad++;
            $display("FAIL load_beat_%0d: rd=%b be=%b addr=%h want 1 %b %h", i, mem_read,
                     mem_byte_enable, mem_address, be[i], {addr[i][31:2], 2'b00});
         end
         mem_beat(rd[i]);
         total++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== exp[i] || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL load_ext_%0d: valid=%b data=%h err=%b want 1 %h 0", i, rsp_valid,
                     rsp_rdata, rsp_err, exp[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_illegal;
      logic        we   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic [2:0]  f3   [4] = '{3'b101, 3'b011, 3'b110, 3'b100};
      logic [31:0] addr [4] = '{32'h001, 32'h008, 32'h010, 32'h020};
      for (int i = 0; i < 4; i++) begin
         drive_req(we[i], f3[i], addr[i], 32'hFFFF_FFFF);
`ifdef MEM_ACCESS_UNIT_SPLIT_EN
         if (i == 0) begin
            // LHU at offset 1 fits in one beat when splitting is enabled.
            total++;
            if (mem_read !== 1'b1 || mem_address !== 32'h0 || mem_byte_enable !== 4'b0110) begin
               bad++;
               $display("FAIL lhu_mis_beat: rd=%b addr=%h be=%b want 1 00000000 0110",
                        mem_read, mem_address, mem_byte_enable);
            end
            mem_beat(32'h00F0_0D00);
            total++;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0000_F00D) begin
               bad++;
               $display("FAIL lhu_mis_rsp: valid=%b err=%b data=%h want 1 0 0000f00d",
                        rsp_valid, rsp_err, rsp_rdata);
            end
            @(posedge clk); #1;
            continue;
         end
`endif
         total++;
         if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 ||
             {mem_read, mem_write} !== 2'b00) begin
            bad++;
            $display("FAIL illegal_%0d: valid=%b err=%b data=%h rd=%b wr=%b want 1 1 0 0 0", i,
                     rsp_valid, rsp_err, rsp_rdata, mem_read, mem_write);
         end
         @(posedge clk); #1;
         total++;
         if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_read !== 1'b0) begin
            bad++;
            $display("FAIL illegal_done_%0d: valid=%b ready=%b rd=%b want 0 1 0", i, rsp_valid,
                     req_ready, mem_read);
         end
      end
   endtask

   task automatic test_split;
`ifdef MEM_ACCESS_UNIT_SPLIT_EN
      drive_req(1'b0, 3'b010, 32'h0FE, 32'h0);
      total++;
      if (mem_read !== 1'b1 || mem_address !== 32'h0FC || mem_byte_enable !== 4'b1100) begin
         bad++;
         $display("FAIL lw_split_b0: rd=%b addr=%h be=%b want 1 000000fc 1100",
                  mem_read, mem_address, mem_byte_enable);
      end
      mem_beat(32'hBBBB_1111);
      total++;
      if (rsp_valid !== 1'b0 || mem_read !== 1'b1 || mem_address !== 32'h100 ||
          mem_byte_enable !== 4'b0011) begin
         bad++;
         $display("FAIL lw_split_b1: valid=%b rd=%b addr=%h be=%b want 0 1 00000100 0011",
                  rsp_valid, mem_read, mem_address, mem_byte_enable);
      end
      mem_beat(32'h2222_AAAA);
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hAAAA_BBBB || rsp_err !== 1'b0) begin
         bad++;
         $display("FAIL lw_split_rsp: valid=%b data=%h err=%b want 1 aaaabbbb 0",
                  rsp_valid, rsp_rdata, rsp_err);
      end
      @(posedge clk); #1;
      drive_req(1'b1, 3'b010, 32'h0FF, 32'h1122_3344);
      total++;
      if (mem_write !== 1'b1 || mem_address !== 32'h0FC || mem_byte_enable !== 4'b1000 ||
          mem_wdata[31:24] !== 8'h44) begin
         bad++;
         $display("FAIL sw_split_b0: wr=%b addr=%h be=%b wdata=%h want 1 000000fc 1000 44xxxxxx",
                  mem_write, mem_address, mem_byte_enable, mem_wdata);
      end
      mem_beat(32'h0);
      total++;
      if (mem_write !== 1'b1 || mem_address !== 32'h100 || mem_byte_enable !== 4'b0111 ||
          mem_wdata[23:0] !== 24'h112233) begin
         bad++;
         $display("FAIL sw_split_b1: wr=%b addr=%h be=%b wdata=%h want 1 00000100 0111 xx112233",
                  mem_write, mem_address, mem_byte_enable, mem_wdata);
      end
      mem_beat(32'h0);
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
         bad++;
         $display("FAIL sw_split_rsp: valid=%b data=%h err=%b want 1 0 0", rsp_valid, rsp_rdata, rsp_err);
      end
      @(posedge clk); #1;
      // Second beat address wraps past the top of the address space.
      drive_req(1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0);
      mem_beat(32'h7F00_0000);
      total++;
      if (mem_address !== 32'h0 || mem_byte_enable !== 4'b0001) begin
         bad++;
         $display("FAIL lh_wrap_b1: addr=%h be=%b want 00000000 0001", mem_address, mem_byte_enable);
      end
      mem_beat(32'h0000_0012);
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_127F) begin
         bad++;
         $display("FAIL lh_wrap_rsp: valid=%b data=%h want 1 0000127f", rsp_valid, rsp_rdata);
      end
      @(posedge clk); #1;
`else
      drive_req(1'b0, 3'b010, 32'h0FE, 32'h0);
      total++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || mem_read !== 1'b0) begin
         bad++;
         $display("FAIL lw_mis_err: valid=%b err=%b rd=%b want 1 1 0", rsp_valid, rsp_err, mem_read);
      end
      @(posedge clk); #1;
      drive_req(1'b1, 3'b010, 32'h0FF, 32'h1122_3344);
      total++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || mem_write !== 1'b0) begin
         bad++;
         $display("FAIL sw_mis_err: valid=%b err=%b wr=%b want 1 1 0", rsp_valid, rsp_err, mem_write);
      end
      @(posedge clk); #1;
`endif
   endtask

   task automatic test_reset_mid;
      drive_req(1'b0, 3'b010, 32'h010, 32'h0);
      total++;
      if (mem_read !== 1'b1) begin
         bad++; $display("FAIL mid_beat0: rd=%b want 1", mem_read);
      end
      #2 rst = 1'b0;
      #1;
      total++;
      if ({req_ready, rsp_valid, rsp_err, mem_read, mem_write, dbg_state} !== 7'b0 ||
          mem_address !== 32'h0 || mem_byte_enable !== 4'h0) begin
         bad++;
         $display("FAIL mid_reset: ready=%b valid=%b rd=%b addr=%h state=%0d want all zero",
                  req_ready, rsp_valid, mem_read, mem_address, dbg_state);
      end
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      mem_beat(32'h0000_0055);
      total++;
      if (rsp_valid !== 1'b0 || mem_read !== 1'b0 || req_ready !== 1'b1) begin
         bad++;
         $display("FAIL stale_resp: valid=%b rd=%b ready=%b want 0 0 1", rsp_valid, mem_read, req_ready);
      end
      drive_req(1'b0, 3'b100, 32'h012, 32'h0);
      mem_beat(32'h00C3_0000);
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_00C3 || rsp_err !== 1'b0) begin
         bad++;
         $display("FAIL post_reset_lbu: valid=%b data=%h err=%b want 1 000000c3 0",
                  rsp_valid, rsp_rdata, rsp_err);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h040;
      @(posedge clk); #1;
      req_addr = 32'h080;
      @(posedge clk); #1;
      total++;
      if (mem_address !== 32'h040 || dbg_state !== 2'd1) begin
         bad++;
         $display("FAIL b2b_ignore: addr=%h state=%0d want 00000040 1", mem_address, dbg_state);
      end
      mem_beat(32'h1111_1111);
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1111_1111) begin
         bad++; $display("FAIL b2b_rsp1: valid=%b data=%h want 1 11111111", rsp_valid, rsp_rdata);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      total++;
      if (mem_read !== 1'b1 || mem_address !== 32'h080) begin
         bad++; $display("FAIL b2b_second: rd=%b addr=%h want 1 00000080", mem_read, mem_address);
      end
      mem_beat(32'h2222_2222);
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h2222_2222) begin
         bad++; $display("FAIL b2b_rsp2: valid=%b data=%h want 1 22222222", rsp_valid, rsp_rdata);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_xlen64;
      logic [2:0]  f3   [3] = '{3'b011, 3'b110, 3'b010};
      logic [31:0] addr [3] = '{32'h008, 32'h004, 32'h00C};
      logic [31:0] beat [3] = '{32'h008, 32'h000, 32'h008};
      logic [7:0]  be   [3] = '{8'hFF, 8'hF0, 8'hF0};
      logic [63:0] rd   [3] = '{64'h8877_6655_4433_2211, 64'h8000_0001_0000_0000, 64'hFEDC_BA98_0000_0000};
      logic [63:0] exp  [3] = '{64'h8877_6655_4433_2211, 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_FEDC_BA98};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         w_req_valid = 1'b1; w_req_funct3 = f3[i]; w_req_addr = addr[i];
         @(posedge clk); #1;
         w_req_valid = 1'b0;
         total++;
         if (w_mem_read !== 1'b1 || w_mem_address !== beat[i] || w_mem_byte_enable !== be[i]) begin
            bad++;
            $display("FAIL x64_beat_%0d: rd=%b addr=%h be=%h want 1 %h %h", i, w_mem_read,
                     w_mem_address, w_mem_byte_enable, beat[i], be[i]);
         end
         w_mem_resp = 1'b1; w_mem_rdata = rd[i];
         @(posedge clk); #1;
         w_mem_resp = 1'b0; w_mem_rdata = '0;
         total++;
         if (w_rsp_valid !== 1'b1 || w_rsp_rdata !== exp[i] || w_rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL x64_rsp_%0d: valid=%b data=%h err=%b want 1 %h 0", i, w_rsp_valid,
                     w_rsp_rdata, w_rsp_err, exp[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
      mem_rdata = '0; mem_resp = 1'b0;
      w_req_valid = 1'b0; w_req_funct3 = '0; w_req_addr = '0; w_req_wdata = '0;
      w_mem_rdata = '0; w_mem_resp = 1'b0;
      test_reset();
      test_lb_wait();
      test_store_sh();
      test_load_ext();
      test_illegal();
      test_split();
      test_reset_mid();
      test_back_to_back();
      test_xlen64();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
      $fatal(1, "timeout");
   end

endmodule
